// File: rtl/riscv_v_wb_buffer.sv
// Vector writeback buffer: DEPTH-entry FIFO between the ALU and the regfile write port, merging same-register tail writes.
// Head is visible one cycle after push with no bypass; wb_ready drops only when full and no tail merge is possible, independent of rf_wr_ready.
module riscv_v_wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [4:0]                 wb_addr,
  input  logic [127:0]               wb_data,
  input  logic [15:0]                wb_byte_valid,
  output logic                       rf_wr_valid,
  input  logic                       rf_wr_ready,
  output logic [4:0]                 rf_wr_addr,
  output logic [15:0]                rf_wr_en,
  output logic [127:0]               rf_wr_data,
  input  logic [4:0]                 rd_addr_a,
  input  logic [4:0]                 rd_addr_b,
  output logic                       hazard_a,
  output logic                       hazard_b,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]   addr;
    logic [15:0]  byte_valid;
    logic [127:0] data;
  } wb_entry_t;

  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;

  logic [AW-1:0]     tail_idx;
  logic              coalesce_ok;
  logic              wb_fire;
  logic              wb_empty;
  logic              do_alloc;
  logic              do_coalesce;
  logic              do_pop;
  logic [DEPTH-1:0]  occ;
  logic [DEPTH-1:0]  hit_a;
  logic [DEPTH-1:0]  hit_b;
  wb_entry_t         head;

  assign tail_idx = wr_ptr - AW'(1);

  // Merging needs at least two entries so the tail can never be the head
  // being popped in the same cycle.
  assign coalesce_ok = (cnt >= CW'(2)) && (wb_addr == mem[tail_idx].addr);
  assign wb_ready    = (cnt < CW'(DEPTH)) || coalesce_ok;

  assign wb_fire     = wb_valid && wb_ready && !rst;
  assign wb_empty    = (wb_byte_valid == 16'h0000);
  assign do_coalesce = wb_fire && !wb_empty && coalesce_ok;
  assign do_alloc    = wb_fire && !wb_empty && !coalesce_ok;
  assign do_pop      = (cnt != '0) && rf_wr_ready && !rst;

  assign head        = mem[rd_ptr];
  assign rf_wr_valid = (cnt != '0);
  assign rf_wr_addr  = head.addr;
  assign rf_wr_data  = head.data;
  assign rf_wr_en    = (cnt != '0) ? head.byte_valid : 16'h0000;
  assign count       = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_alloc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_alloc, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      mem[wr_ptr].addr       <= wb_addr;
      mem[wr_ptr].byte_valid <= wb_byte_valid;
      mem[wr_ptr].data       <= wb_data;
    end else if (do_coalesce) begin
      mem[tail_idx].byte_valid <= mem[tail_idx].byte_valid | wb_byte_valid;
      for (int b = 0; b < 16; b++) begin
        if (wb_byte_valid[b]) begin
          mem[tail_idx].data[8*b +: 8] <= wb_data[8*b +: 8];
        end
      end
    end
  end

  // A slot is occupied when its distance from the head is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [AW-1:0] rel;
    assign rel      = AW'(g) - rd_ptr;
    assign occ[g]   = ({1'b0, rel} < cnt);
    assign hit_a[g] = occ[g] && (mem[g].addr == rd_addr_a);
    assign hit_b[g] = occ[g] && (mem[g].addr == rd_addr_b);
  end

  assign hazard_a = |hit_a;
  assign hazard_b = |hit_b;

endmodule

// File: tb/tb_riscv_v_wb_buffer.sv
// Directed bench for riscv_v_wb_buffer: single write, backpressure fill, coalesce, full-with-pop, empty writes, reset.
module tb_riscv_v_wb_buffer;

  logic         clk;
  logic         rst;
  logic         wb_valid;
  logic         wb_ready;
  logic [4:0]   wb_addr;
  logic [127:0] wb_data;
  logic [15:0]  wb_byte_valid;
  logic         rf_wr_valid;
  logic         rf_wr_ready;
  logic [4:0]   rf_wr_addr;
  logic [15:0]  rf_wr_en;
  logic [127:0] rf_wr_data;
  logic [4:0]   rd_addr_a;
  logic [4:0]   rd_addr_b;
  logic         hazard_a;
  logic         hazard_b;
  logic [2:0]   count;

  int n_checks;
  int n_fail;

  riscv_v_wb_buffer #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .wb_byte_valid (wb_byte_valid),
    .rf_wr_valid   (rf_wr_valid),
    .rf_wr_ready   (rf_wr_ready),
    .rf_wr_addr    (rf_wr_addr),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_data    (rf_wr_data),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .hazard_a      (hazard_a),
    .hazard_b      (hazard_b),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic [4:0] a, input logic [127:0] d, input logic [15:0] bv);
    wb_valid      = 1'b1;
    wb_addr       = a;
    wb_data       = d;
    wb_byte_valid = bv;
  endtask

  task automatic idle_wb();
    wb_valid      = 1'b0;
    wb_addr       = 5'd0;
    wb_data       = '0;
    wb_byte_valid = 16'h0000;
  endtask

  task automatic push(input logic [4:0] a, input logic [127:0] d, input logic [15:0] bv);
    drive_wb(a, d, bv);
    tick();
    idle_wb();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] bt;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    rf_wr_ready = 1'b0;
    rd_addr_a   = 5'd0;
    rd_addr_b   = 5'd0;
    idle_wb();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // reset state
    chk("rst_valid", rf_wr_valid, 1'b0);
    chk("rst_en",    rf_wr_en,    16'h0000);
    chk("rst_ready", wb_ready,    1'b1);
    chk("rst_hz_a",  hazard_a,    1'b0);
    chk("rst_hz_b",  hazard_b,    1'b0);
    chk("rst_count", count,       3'd0);

    // single write with ready regfile
    rf_wr_ready = 1'b1;
    drive_wb(5'd3, {16{8'h0F}}, 16'hFFFF);
    #1;
    chk("t1_wb_ready", wb_ready, 1'b1);
    tick();
    idle_wb();
    #1;
    chk("t1_valid", rf_wr_valid, 1'b1);
    chk("t1_addr",  rf_wr_addr,  5'd3);
    chk("t1_en",    rf_wr_en,    16'hFFFF);
    chk("t1_data",  rf_wr_data,  {16{8'h0F}});
    chk("t1_count", count,       3'd1);
    tick();
    chk("t1_count_after", count,       3'd0);
    chk("t1_valid_after", rf_wr_valid, 1'b0);

    // backpressure fill
    rf_wr_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bt = 8'(i);
      push(5'(i), {16{bt}}, 16'hFFFF);
    end
    #1;
    chk("t2_count", count, 3'd4);
    drive_wb(5'd5, {16{8'h05}}, 16'hFFFF);
    #1;
    chk("t2_full_ready", wb_ready, 1'b0);
    idle_wb();
    rd_addr_a = 5'd2;
    rd_addr_b = 5'd4;
    #1;
    chk("t2_hz_a_2", hazard_a, 1'b1);
    chk("t2_hz_b_4", hazard_b, 1'b1);
    rd_addr_a = 5'd7;
    rd_addr_b = 5'd7;
    #1;
    chk("t2_hz_a_7", hazard_a, 1'b0);
    chk("t2_hz_b_7", hazard_b, 1'b0);
    tick();
    chk("t2_stall_count", count,      3'd4);
    chk("t2_stall_head",  rf_wr_addr, 5'd1);
    rf_wr_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bt = 8'(i);
      #1;
      chk("t2_drain_addr", rf_wr_addr, 5'(i));
      chk("t2_drain_data", rf_wr_data, {16{bt}});
      tick();
    end
    chk("t2_drained", count, 3'd0);

    // coalesce into the tail while not full
    rf_wr_ready = 1'b0;
    push(5'd1, {16{8'hAA}}, 16'hFFFF);
    push(5'd2, {16{8'h11}}, 16'h00FF);
    drive_wb(5'd2, {16{8'h22}}, 16'hFF00);
    #1;
    chk("t3_coal_ready", wb_ready, 1'b1);
    tick();
    idle_wb();
    #1;
    chk("t3_count", count,      3'd2);
    chk("t3_head",  rf_wr_addr, 5'd1);
    rf_wr_ready = 1'b1;
    tick();
    rf_wr_ready = 1'b0;
    #1;
    chk("t3_second_addr", rf_wr_addr, 5'd2);
    chk("t3_second_en",   rf_wr_en,   16'hFFFF);
    chk("t3_second_data", rf_wr_data, {{8{8'h22}}, {8{8'h11}}});
    rf_wr_ready = 1'b1;
    tick();
    chk("t3_drained", count, 3'd0);

    // full with simultaneous pop
    rf_wr_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bt = 8'(i);
      push(5'(i), {16{bt}}, 16'hFFFF);
    end
    rf_wr_ready = 1'b1;
    drive_wb(5'd6, {16{8'h06}}, 16'hFFFF);
    #1;
    chk("t4_full_pop_ready", wb_ready, 1'b0);
    tick();
    idle_wb();
    #1;
    chk("t4_count3", count,      3'd3);
    chk("t4_head2",  rf_wr_addr, 5'd2);
    rf_wr_ready = 1'b0;
    push(5'd5, {16{8'h05}}, 16'hFFFF);
    #1;
    chk("t4_refill", count, 3'd4);
    rf_wr_ready = 1'b1;
    drive_wb(5'd5, {16{8'h55}}, 16'h000F);
    #1;
    chk("t4_coal_ready", wb_ready, 1'b1);
    tick();
    idle_wb();
    #1;
    chk("t4_coal_count", count,      3'd3);
    chk("t4_head3",      rf_wr_addr, 5'd3);
    tick();
    chk("t4_head4", rf_wr_addr, 5'd4);
    tick();
    chk("t4_tail_addr", rf_wr_addr, 5'd5);
    chk("t4_tail_en",   rf_wr_en,   16'hFFFF);
    chk("t4_tail_data", rf_wr_data, {{12{8'h05}}, {4{8'h55}}});
    tick();
    chk("t4_drained", count, 3'd0);

    // empty byte-valid writes are accepted and dropped
    rf_wr_ready = 1'b0;
    drive_wb(5'd7, {16{8'h77}}, 16'h0000);
    #1;
    chk("t5_empty_ready", wb_ready, 1'b1);
    tick();
    idle_wb();
    #1;
    chk("t5_empty_count", count,       3'd0);
    chk("t5_empty_valid", rf_wr_valid, 1'b0);

    // single-entry same-address writes allocate rather than merge
    push(5'd9, {16{8'h09}}, 16'hFFFF);
    push(5'd9, {16{8'h19}}, 16'hFFFF);
    #1;
    chk("t5_no_coal_count", count, 3'd2);
    push(5'd10, {16{8'h0A}}, 16'hFFFF);
    rd_addr_a = 5'd9;
    rd_addr_b = 5'd10;
    #1;
    chk("t5_pre_rst_count", count,    3'd3);
    chk("t5_pre_rst_hz_a",  hazard_a, 1'b1);
    chk("t5_pre_rst_hz_b",  hazard_b, 1'b1);

    // reset mid-operation with a push and pop presented
    rst         = 1'b1;
    rf_wr_ready = 1'b1;
    drive_wb(5'd11, {16{8'h0B}}, 16'hFFFF);
    tick();
    rst         = 1'b0;
    rf_wr_ready = 1'b0;
    idle_wb();
    #1;
    chk("t6_count", count,       3'd0);
    chk("t6_valid", rf_wr_valid, 1'b0);
    chk("t6_en",    rf_wr_en,    16'h0000);
    chk("t6_hz_a",  hazard_a,    1'b0);
    chk("t6_hz_b",  hazard_b,    1'b0);
    chk("t6_ready", wb_ready,    1'b1);
    push(5'd12, {16{8'h0C}}, 16'hFFFF);
    #1;
    chk("t6_post_count", count,      3'd1);
    chk("t6_post_head",  rf_wr_addr, 5'd12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
